// File: rtl/scalar_mul_transfer_sequencer.sv
// Descriptor FIFO + sequencer feeding the scalar-mul RAM transfer engine: pops one
// descriptor, presents the command one cycle before a single-cycle strobe, waits for the
// completion interrupt, then idles GAP cycles. Macro SEQ_TIMEOUT_EN adds a WAIT timeout.
module scalar_mul_transfer_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 31,
    parameter int GAP     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     desc_valid,
    output logic                     desc_ready,
    input  logic                     desc_dir,
    input  logic [ADDR_W-1:0]        desc_rd_addr,
    input  logic [ADDR_W-1:0]        desc_wr_addr,
    input  logic [1:0]               desc_chunks,
    input  logic                     desc_last,
    output logic                     read_write_command,
    output logic [ADDR_W-1:0]        read_address,
    output logic [ADDR_W-1:0]        write_address,
    output logic [1:0]               no_of_chunks,
    output logic                     command_transfer,
    input  logic                     interupt_transfer,
    output logic                     busy,
    output logic                     seq_done,
    output logic                     error,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * ADDR_W + 4;
    localparam int GW = $clog2(GAP + 1) + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_ERR} state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [GW-1:0]   gap_cnt;
    logic            last_q;
    logic            empty, full, push, pop, flush;

    assign queue_count      = wr_ptr - rd_ptr;
    assign empty            = (wr_ptr == rd_ptr);
    assign full             = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign desc_ready       = !full;
    assign push             = desc_valid && !full && !flush;
    assign command_transfer = (state == S_ISSUE);
    assign busy             = (state != S_IDLE);

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT);
    logic [TW-1:0] wait_cnt;
    logic          error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (flush)
                error_q <= 1'b1;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            // Zero-chunk descriptors skip the strobe but still pass through GAP.
            S_LOAD:  state_nxt = (no_of_chunks == 2'b00) ? S_GAP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (interupt_transfer)
                    state_nxt = S_GAP;
`ifdef SEQ_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    flush     = 1'b1;
                    state_nxt = S_ERR;
                end
`endif
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {desc_last, desc_dir, desc_rd_addr, desc_wr_addr, desc_chunks};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            gap_cnt            <= '0;
            last_q             <= 1'b0;
            read_write_command <= 1'b0;
            read_address       <= '0;
            write_address      <= '0;
            no_of_chunks       <= 2'b00;
            seq_done           <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    {last_q, read_write_command, read_address, write_address, no_of_chunks}
                        <= mem[rd_ptr[AW-1:0]];
                end
            end
            gap_cnt  <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
            seq_done <= last_q && (((state == S_WAIT) && interupt_transfer) ||
                                   ((state == S_LOAD) && (no_of_chunks == 2'b00)));
        end
    end

endmodule

// File: tb/tb_scalar_mul_transfer_sequencer.sv
// Self-checking bench: scoreboard of expected engine commands with an engine interrupt model.
module tb_scalar_mul_transfer_sequencer;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 31;
    localparam int GAP     = 2;

    typedef logic [2*ADDR_W+2:0] cmd_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   desc_valid = 1'b0;
    logic                   desc_ready;
    logic                   desc_dir = 1'b0;
    logic [ADDR_W-1:0]      desc_rd_addr = '0;
    logic [ADDR_W-1:0]      desc_wr_addr = '0;
    logic [1:0]             desc_chunks = 2'b00;
    logic                   desc_last = 1'b0;
    logic                   read_write_command;
    logic [ADDR_W-1:0]      read_address;
    logic [ADDR_W-1:0]      write_address;
    logic [1:0]             no_of_chunks;
    logic                   command_transfer;
    logic                   interupt_transfer = 1'b0;
    logic                   busy;
    logic                   seq_done;
    logic                   error;
    logic [$clog2(DEPTH):0] queue_count;

    scalar_mul_transfer_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_dir(desc_dir),
        .desc_rd_addr(desc_rd_addr), .desc_wr_addr(desc_wr_addr),
        .desc_chunks(desc_chunks), .desc_last(desc_last),
        .read_write_command(read_write_command), .read_address(read_address),
        .write_address(write_address), .no_of_chunks(no_of_chunks),
        .command_transfer(command_transfer), .interupt_transfer(interupt_transfer),
        .busy(busy), .seq_done(seq_done), .error(error), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    cmd_t exp_q[$];
    int   exp_seq = 0, seq_cnt = 0, strobe_cnt = 0;
    int   cyc = 0, last_int_cyc = -1, push_cyc = 0, strobe_cyc = 0, fall_cyc = 0;
    bit   in_wait = 1'b0;
    bit   eng_auto = 1'b1;
    int   eng_lat = 7;
    cmd_t cur;
    logic prev_ct = 1'b0, prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: every strobe must match the oldest outstanding command, held until its interrupt.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (in_wait && !command_transfer)
                check("hold", {read_write_command, read_address, write_address, no_of_chunks}, cur);
            if (interupt_transfer && in_wait) begin
                in_wait      = 1'b0;
                last_int_cyc = cyc;
            end
            if (command_transfer) begin
                check("strobe_one_cycle", prev_ct, 1'b0);
                strobe_cnt++;
                strobe_cyc = cyc;
                if (last_int_cyc >= 0)
                    check("int_to_strobe_gap", ((cyc - last_int_cyc) >= GAP + 2), 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1'b1, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    check("cmd", {read_write_command, read_address, write_address, no_of_chunks}, cur);
                end
                in_wait = 1'b1;
            end
            if (seq_done)
                seq_cnt++;
            if (prev_busy && !busy)
                fall_cyc = cyc;
            prev_ct   = command_transfer;
            prev_busy = busy;
        end
    end

    // Engine model: completion pulse eng_lat cycles after each strobe.
    initial forever begin
        @(negedge clk);
        if (command_transfer && eng_auto && rst_n) begin
            repeat (eng_lat) @(posedge clk);
            #1 interupt_transfer = 1'b1;
            @(posedge clk);
            #1 interupt_transfer = 1'b0;
        end
    end

    task automatic push(input logic dir, input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] wr,
                        input logic [1:0] ch, input logic last);
        desc_dir     = dir;
        desc_rd_addr = rd;
        desc_wr_addr = wr;
        desc_chunks  = ch;
        desc_last    = last;
        desc_valid   = 1'b1;
        @(posedge clk);
        #1;
        push_cyc   = cyc;
        desc_valid = 1'b0;
        if (ch != 2'b00)
            exp_q.push_back({dir, rd, wr, ch});
        if (last)
            exp_seq++;
    endtask

    task automatic fire_int();
        interupt_transfer = 1'b1;
        @(posedge clk);
        #1 interupt_transfer = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (desc_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_strobe(input int s0, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (strobe_cnt > s0) ok = 1'b1;
        end
        if (!ok) check("strobe_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (!busy && queue_count == 0 && exp_q.size() == 0 && !in_wait) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, q0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_desc_ready", desc_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_strobe", command_transfer, 1'b0);
        check("rst_seq_done", seq_done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_queue_count", queue_count, 0);
        check("rst_cmd_outputs", {read_write_command, read_address, write_address, no_of_chunks}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single descriptor
        eng_lat = 7;
        push(1'b1, 6'h10, 6'h20, 2'b11, 1'b1);
        wait_idle(200);
        check("t1_strobe_latency", strobe_cyc - push_cyc, 2);
        check("t1_seq_done_count", seq_cnt, exp_seq);
        check("t1_busy_fall", fall_cyc - last_int_cyc, GAP + 1);

        // Fill the FIFO behind a stalled transfer
        eng_auto = 1'b0;
        s0 = strobe_cnt;
        push(1'b0, 6'h01, 6'h02, 2'b01, 1'b0);
        wait_strobe(s0, 50);
        push(1'b1, 6'h03, 6'h04, 2'b10, 1'b0);
        push(1'b0, 6'h05, 6'h06, 2'b11, 1'b0);
        push(1'b1, 6'h07, 6'h08, 2'b01, 1'b0);
        push(1'b0, 6'h09, 6'h0a, 2'b10, 1'b1);
        check("t2_ready_full", desc_ready, 1'b0);
        check("t2_count_full", queue_count, 4);
        desc_dir = 1'b1; desc_rd_addr = 6'h3f; desc_wr_addr = 6'h3e;
        desc_chunks = 2'b11; desc_last = 1'b1; desc_valid = 1'b1;
        @(posedge clk);
        #1 desc_valid = 1'b0;
        check("t2_count_after_drop", queue_count, 4);
        eng_auto = 1'b1;
        eng_lat  = 3;
        fire_int();
        wait_idle(500);
        check("t2_seq_done_count", seq_cnt, exp_seq);

        // Zero-chunk descriptor, then a normal one
        s0 = strobe_cnt;
        push(1'b0, 6'h11, 6'h12, 2'b00, 1'b1);
        push(1'b1, 6'h13, 6'h14, 2'b10, 1'b1);
        wait_idle(300);
        check("t3_strobes", strobe_cnt - s0, 1);
        check("t3_seq_done_count", seq_cnt, exp_seq);

        // Stray interrupt while idle
        q0 = seq_cnt;
        fire_int();
        @(posedge clk);
        #1;
        check("stray_busy", busy, 1'b0);
        check("stray_seq_done", seq_cnt, q0);

        // Push and pop on the same edge at count 2
        eng_auto = 1'b0;
        s0 = strobe_cnt;
        push(1'b1, 6'h21, 6'h22, 2'b01, 1'b0);
        wait_strobe(s0, 50);
        push(1'b0, 6'h23, 6'h24, 2'b10, 1'b0);
        push(1'b1, 6'h25, 6'h26, 2'b11, 1'b0);
        check("t4_count_before", queue_count, 2);
        eng_auto = 1'b1;
        fire_int();
        for (int i = 0; i < GAP - 1; i++) begin
            @(posedge clk);
            #1;
        end
        push(1'b0, 6'h27, 6'h28, 2'b01, 1'b1);
        check("t4_count_pushpop", queue_count, 2);
        wait_idle(500);
        check("t4_seq_done_count", seq_cnt, exp_seq);

        // Nine descriptors through the wrapping pointers
        for (int i = 0; i < 9; i++) begin
            wait_ready(200);
            eng_lat = $urandom_range(1, 5);
            push(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                 2'($urandom_range(1, 3)), (i == 8));
        end
        wait_idle(2000);
        check("t5_seq_done_count", seq_cnt, exp_seq);
        check("t5_error", error, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        eng_auto = 1'b0;
        s0 = strobe_cnt;
        push(1'b1, 6'h31, 6'h32, 2'b01, 1'b0);
        push(1'b0, 6'h33, 6'h34, 2'b10, 1'b0);
        wait_strobe(s0, 50);
        repeat (TIMEOUT + 4) @(posedge clk);
        #1;
        check("to_error", error, 1'b1);
        check("to_flushed", queue_count, 0);
        check("to_busy", busy, 1'b1);
        exp_q.delete();
        in_wait = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("to_error_cleared", error, 1'b0);
        s0 = strobe_cnt;
        push(1'b1, 6'h35, 6'h36, 2'b11, 1'b0);
        wait_strobe(s0, 50);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wait_busy", busy, 1'b0);
        check("rst_mid_wait_cmd", {read_write_command, read_address, write_address, no_of_chunks}, 0);
        check("rst_mid_wait_ready", desc_ready, 1'b1);
        check("rst_mid_wait_count", queue_count, 0);
        in_wait = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
